// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, 16x oversampling with a 3-sample majority vote,
// show-ahead FIFO and sticky framing/overrun/underrun flags.
module uart_rx_core #(
  parameter int CLK_DIV = 27,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               rx_rden,
  output logic [7:0]         rx_rdata,
  output logic               rx_fifo_dvalid,
  output logic               rx_fifo_full,
  output logic [FIFO_AW:0]   rx_fifo_rcntr,
  output logic               rx_fifo_overrun,
  output logic               rx_fifo_underrun,
  output logic               rx_frame_err,
  input  logic               err_clr
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_e;

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [15:0]      DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

  logic rx_s1_q, rxs_q, rxs_dly_q;

  state_e       state_q, state_d;
  logic [15:0]  div_q, div_d;
  logic [3:0]   tk_q, tk_d;
  logic [2:0]   bit_q, bit_d;
  logic [1:0]   smp_q, smp_d;
  logic [7:0]   sh_q, sh_d;
  logic         push_q, push_d;
  logic         ferr_set_q, ferr_set_d;
  logic         tick, maj;

  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               dvalid_q, dvalid_d, full_q, full_d;
  logic               ovr_q, ovr_d, udr_q, udr_d, ferr_q, ferr_d;
  logic               empty, full, do_push, do_pop;

  assign tick = (div_q == DIV_MAX);
  // smp_q[0] holds the tk=7 sample, smp_q[1] the tk=8 sample; the tk=9 sample is live rxs
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? 16'd0 : div_q + 16'd1;
    tk_d       = tick ? tk_q + 4'd1 : tk_q;
    bit_d      = bit_q;
    smp_d      = smp_q;
    sh_d       = sh_q;
    push_d     = 1'b0;
    ferr_set_d = 1'b0;
    if (tick && tk_q == 4'd7) smp_d[0] = rxs_q;
    if (tick && tk_q == 4'd8) smp_d[1] = rxs_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        tk_d  = '0;
        if (rxs_dly_q && !rxs_q) state_d = START;
      end
      START: if (tick) begin
        if (tk_q == 4'd9 && maj) state_d = IDLE;
        if (tk_q == 4'd15) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: if (tick) begin
        if (tk_q == 4'd9) sh_d = {maj, sh_q[7:1]};
        if (tk_q == 4'd15) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: if (tick && tk_q == 4'd9) begin
        if (maj) begin
          push_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_set_d = 1'b1;
          state_d    = WAITHI;
        end
      end
      WAITHI: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign do_pop  = rx_rden & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_push = push_q & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = sh_q;
      wp_d        = wp_q + 1'b1;
    end
    if (do_pop) rp_d = rp_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    dvalid_d = (cnt_d != '0);
    full_d   = (cnt_d == DEPTH_C);
    ovr_d    = (push_q & full & ~do_pop) | (ovr_q & ~err_clr);
    udr_d    = (rx_rden & empty) | (udr_q & ~err_clr);
    ferr_d   = ferr_set_q | (ferr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_dly_q  <= 1'b1;
      state_q    <= IDLE;
      div_q      <= '0;
      tk_q       <= '0;
      bit_q      <= '0;
      smp_q      <= '0;
      sh_q       <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      mem_q      <= '{default: '0};
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      dvalid_q   <= 1'b0;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rxs_q      <= rx_s1_q;
      rxs_dly_q  <= rxs_q;
      state_q    <= state_d;
      div_q      <= div_d;
      tk_q       <= tk_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      sh_q       <= sh_d;
      push_q     <= push_d;
      ferr_set_q <= ferr_set_d;
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      dvalid_q   <= dvalid_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_rdata         = mem_q[rp_q];
  assign rx_fifo_dvalid   = dvalid_q;
  assign rx_fifo_full     = full_q;
  assign rx_fifo_rcntr    = cnt_q;
  assign rx_fifo_overrun  = ovr_q;
  assign rx_fifo_underrun = udr_q;
  assign rx_frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLK_DIV=4 (64 clks per bit): scoreboard queue of expected bytes,
// one task per scenario.
module tb_uart_rx_core;
  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 3;
  localparam int BIT     = 16 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst_n, rx, rx_rden, err_clr;
  logic [7:0]       rx_rdata;
  logic             rx_fifo_dvalid, rx_fifo_full;
  logic [FIFO_AW:0] rx_fifo_rcntr;
  logic             rx_fifo_overrun, rx_fifo_underrun, rx_frame_err;

  int         cyc = 0;
  int         start_cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] q[$];

  uart_rx_core #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_rden(rx_rden),
    .rx_rdata(rx_rdata), .rx_fifo_dvalid(rx_fifo_dvalid), .rx_fifo_full(rx_fifo_full),
    .rx_fifo_rcntr(rx_fifo_rcntr), .rx_fifo_overrun(rx_fifo_overrun),
    .rx_fifo_underrun(rx_fifo_underrun), .rx_frame_err(rx_frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits until cyc == start_cyc + off (sampled #1 after the edge)
  task automatic wait_rel(input int off, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (cyc == start_cyc + off) ok = 1'b1;
    end
  endtask

  // Bad stop bit: line held low 200 clks from the stop bit, then high for one bit
  task automatic send_byte(input logic [7:0] d, input bit stop_hi);
    rx = 1'b0;
    start_cyc = cyc;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clks(BIT);
    end
    if (stop_hi) begin
      rx = 1'b1;
      clks(BIT);
    end else begin
      rx = 1'b0;
      clks(200);
      rx = 1'b1;
      clks(BIT);
    end
  endtask

  task automatic send_model(input logic [7:0] d);
    send_byte(d, 1'b1);
    if (q.size() < 8) q.push_back(d);
  endtask

  task automatic pop_check(input string nm);
    logic [7:0] exp;
    exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
    n_chk++;
    if (rx_fifo_dvalid !== 1'b1 || rx_rdata !== exp) begin
      n_fail++;
      $display("FAIL %s: dvalid=%b rdata=%h, required dvalid=1 rdata=%h", nm, rx_fifo_dvalid, rx_rdata, exp);
    end
    rx_rden = 1'b1;
    clks(1);
    rx_rden = 1'b0;
    clks(1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
  endtask

  // Sends a frame and pulses rx_rden (use_clr=0) or err_clr (use_clr=1) in the push/error cycle
  task automatic send_pulse(input logic [7:0] d, input bit stop_hi, input bit use_clr);
    bit ok;
    logic [7:0] exp;
    fork
      send_byte(d, stop_hi);
      begin
        wait_rel(10 * BIT - 6 * CLK_DIV + 3, ok);
        n_chk++;
        if (!ok) begin
          n_fail++;
          $display("FAIL sim_pulse_timing: cycle %0d never reached", start_cyc + 619);
        end
        if (use_clr) err_clr = 1'b1;
        else begin
          rx_rden = 1'b1;
          if (q.size() > 0) begin
            exp = q.pop_front();
            n_chk++;
            if (rx_rdata !== exp) begin
              n_fail++;
              $display("FAIL sim_pop_data: rdata=%h, required %h", rx_rdata, exp);
            end
          end
        end
        clks(1);
        rx_rden = 1'b0;
        err_clr = 1'b0;
      end
    join
    if (stop_hi) q.push_back(d);
  endtask

  task automatic test_reset();
    bit bad;
    rx = 1'b1; rx_rden = 1'b0; err_clr = 1'b0; rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    n_chk++;
    if ({rx_rdata, rx_fifo_dvalid, rx_fifo_full, rx_fifo_rcntr} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_fifo: rdata=%h dvalid=%b full=%b cnt=%0d, required all 0", rx_rdata, rx_fifo_dvalid, rx_fifo_full, rx_fifo_rcntr);
    end
    n_chk++;
    if ({rx_fifo_overrun, rx_fifo_underrun, rx_frame_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: ovr=%b udr=%b ferr=%b, required 000", rx_fifo_overrun, rx_fifo_underrun, rx_frame_err);
    end
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_fifo_rcntr !== '0 || rx_fifo_overrun !== 1'b0 || rx_fifo_underrun !== 1'b0 || rx_frame_err !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: count or flag left 0 during 2000 idle clks, required stay at 0");
    end
    clks(1);
  endtask

  task automatic test_single_byte();
    bit got;
    int rise;
    got = 1'b0;
    rise = 0;
    fork
      send_model(8'hA5);
      begin
        #2;
        for (int i = 0; i < 1000 && !got; i++) begin
          @(negedge clk);
          if (rx_fifo_dvalid === 1'b1) begin
            got = 1'b1;
            rise = cyc;
          end
        end
      end
    join
    n_chk++;
    if (!got || rise != start_cyc + 620) begin
      n_fail++;
      $display("FAIL single_timing: dvalid rose at %0d (seen=%b), required %0d", rise, got, start_cyc + 620);
    end
    n_chk++;
    if (int'(rx_fifo_rcntr) != 1) begin
      n_fail++;
      $display("FAIL single_count: cnt=%0d, required 1", rx_fifo_rcntr);
    end
    pop_check("single_data");
    n_chk++;
    if (rx_fifo_rcntr !== '0 || rx_fifo_dvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: cnt=%0d dvalid=%b, required 0 0", rx_fifo_rcntr, rx_fifo_dvalid);
    end
  endtask

  task automatic test_glitch_framing();
    rx = 1'b0;
    clks(20);
    rx = 1'b1;
    clks(700);
    n_chk++;
    if (rx_fifo_rcntr !== '0 || rx_frame_err !== 1'b0 || rx_fifo_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch: cnt=%0d ferr=%b udr=%b, required 0 0 0", rx_fifo_rcntr, rx_frame_err, rx_fifo_underrun);
    end
    send_byte(8'h3C, 1'b0);
    n_chk++;
    if (rx_frame_err !== 1'b1 || rx_fifo_rcntr !== '0) begin
      n_fail++;
      $display("FAIL frame_err: ferr=%b cnt=%0d, required 1 0", rx_frame_err, rx_fifo_rcntr);
    end
    send_model(8'h11);
    pop_check("after_frame_err");
  endtask

  task automatic test_full_overrun();
    for (int i = 1; i <= 9; i++) begin
      send_model(8'(i));
      if (i == 8) begin
        n_chk++;
        if (rx_fifo_full !== 1'b1 || rx_fifo_overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL full_after_8: full=%b ovr=%b, required 1 0", rx_fifo_full, rx_fifo_overrun);
        end
      end
    end
    n_chk++;
    if (rx_fifo_overrun !== 1'b1 || int'(rx_fifo_rcntr) != 8) begin
      n_fail++;
      $display("FAIL overrun: ovr=%b cnt=%0d, required 1 8", rx_fifo_overrun, rx_fifo_rcntr);
    end
    for (int i = 0; i < 8; i++) pop_check("full_order");
    n_chk++;
    if (rx_fifo_rcntr !== '0 || rx_fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: cnt=%0d full=%b, required 0 0", rx_fifo_rcntr, rx_fifo_full);
    end
    pulse_clr();
    n_chk++;
    if (rx_fifo_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clr: ovr=%b, required 0", rx_fifo_overrun);
    end
  endtask

  task automatic test_underrun_simul();
    rx_rden = 1'b1;
    clks(1);
    rx_rden = 1'b0;
    clks(1);
    n_chk++;
    if (rx_fifo_underrun !== 1'b1 || rx_fifo_rcntr !== '0) begin
      n_fail++;
      $display("FAIL underrun: udr=%b cnt=%0d, required 1 0", rx_fifo_underrun, rx_fifo_rcntr);
    end
    pulse_clr();
    send_pulse(8'h77, 1'b1, 1'b0);
    n_chk++;
    if (rx_fifo_underrun !== 1'b1 || int'(rx_fifo_rcntr) != 1) begin
      n_fail++;
      $display("FAIL empty_push_pop: udr=%b cnt=%0d, required 1 1", rx_fifo_underrun, rx_fifo_rcntr);
    end
    pop_check("empty_push_pop_data");
    for (int i = 0; i < 8; i++) send_model(8'h80 + 8'(i));
    send_pulse(8'h88, 1'b1, 1'b0);
    n_chk++;
    if (int'(rx_fifo_rcntr) != 8 || rx_fifo_overrun !== 1'b0 || rx_fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: cnt=%0d ovr=%b full=%b, required 8 0 1", rx_fifo_rcntr, rx_fifo_overrun, rx_fifo_full);
    end
    for (int i = 0; i < 8; i++) pop_check("full_push_pop_order");
    pulse_clr();
    n_chk++;
    if (rx_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_clr: ferr=%b, required 0", rx_frame_err);
    end
    send_pulse(8'h3C, 1'b0, 1'b1);
    n_chk++;
    if (rx_frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_set_wins: ferr=%b, required 1", rx_frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    fork
      send_byte(8'hF3, 1'b1);
      begin
        wait_rel(5 * BIT + BIT / 2, ok);
        n_chk++;
        if (!ok) begin
          n_fail++;
          $display("FAIL midreset_timing: data bit 4 never reached");
        end
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
      end
    join
    q.delete();
    clks(100);
    n_chk++;
    if (rx_fifo_rcntr !== '0 || rx_fifo_dvalid !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_lost: cnt=%0d dvalid=%b ferr=%b, required 0 0 0", rx_fifo_rcntr, rx_fifo_dvalid, rx_frame_err);
    end
    send_model(8'h5A);
    pop_check("after_midreset");
    n_chk++;
    if (rx_fifo_rcntr !== '0) begin
      n_fail++;
      $display("FAIL midreset_drain: cnt=%0d, required 0", rx_fifo_rcntr);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch_framing();
    test_full_overrun();
    test_underrun_simul();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end for the UART monitor. It sits directly upstream of the monitor's receive-side loop and command logic. It takes the raw `rx` pin, synchronises it, and recovers 8N1 bytes using 16x oversampling with majority voting. Recovered bytes are buffered in a show-ahead FIFO, read by the consumer through the `rx_rden`/`rx_rdata`/`rx_fifo_*` handshake, and framing, overrun and underrun conditions are reported as sticky flags.

## Interface
- `CLK_DIV`, 27: clk cycles per oversample tick, range 2..65535. Bit period is 16 ticks.
- `FIFO_AW`, 3: FIFO address width. Depth is 2^FIFO_AW entries.

- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `rx`  in  1  asynchronous serial input; idle high
- `rx_rden`  in  1  pop head entry this cycle
- `rx_rdata`  out  8  FIFO head byte; valid while `rx_fifo_dvalid`=1
- `rx_fifo_dvalid`  out  1  FIFO not empty
- `rx_fifo_full`  out  1  FIFO holds 2^FIFO_AW entries
- `rx_fifo_rcntr`  out  FIFO_AW+1  current entry count
- `rx_fifo_overrun`  out  1  sticky: byte received while full
- `rx_fifo_underrun`  out  1  sticky: `rx_rden` while empty
- `rx_frame_err`  out  1  sticky: stop bit sampled low
- `err_clr`  in  1  clears all three sticky flags

## Operation
- **Input synchroniser.** `rx` passes through two flops; the result is `rxs`. The synchroniser flops reset to 1. `rxs_d` is `rxs` delayed one cycle.
- **Tick divider.**
  - In IDLE, the divider and the 4-bit tick counter `tk` are held at 0.
  - Otherwise the divider counts 0..CLK_DIV-1. A tick occurs when it reaches CLK_DIV-1.
  - `tk` increments on every tick and wraps 15→0. Each wrap advances the bit index.
- **State machine.** States are IDLE, START, DATA, STOP and WAITHI.
  - IDLE: when `rxs_d`=1 and `rxs`=0 (call this cycle E), go to START.
  - In START, DATA and STOP, the line is sampled at ticks `tk`=7, 8 and 9. The bit value is the majority of the three samples, decided on the `tk`=9 tick.
  - START: if the decided value is 1, it is a false start; go to IDLE with no other effect. If 0, continue. At the `tk`=15 tick, go to DATA with bit index 0.
  - DATA: shift the decided bit into the shift register, LSB first. After the `tk`=15 tick of bit 7, go to STOP.
  - STOP, decided value 1: assert `push` for one cycle with the shift register contents, then go to IDLE.
  - STOP, decided value 0: set `rx_frame_err`, discard the byte, go to WAITHI.
  - WAITHI: stay until `rxs`=1, then go to IDLE.
- **FIFO.**
  - Storage is a circular buffer. Write and read pointers are FIFO_AW bits wide and wrap modulo the depth.
  - `rx_rdata` is the entry at the read pointer (show-ahead). Its value is don't-care when empty.
  - A push while not full writes the byte and increments the count.
  - A push while full drops the byte and sets `rx_fifo_overrun`. Count and contents are unchanged.
  - `rx_rden` while not empty advances the read pointer.
  - `rx_rden` while empty sets `rx_fifo_underrun`. Pointers are unchanged.
  - Push and pop in the same cycle while full: both are accepted, the count stays at full, and no overrun is flagged.
  - Push and pop in the same cycle while empty: the push is accepted, underrun is flagged, and the count becomes 1.
- **Sticky flags.** `err_clr` clears the flags. If a set condition occurs in the same cycle as `err_clr`, the set wins.
- **Reset.** Applies on any `clk` edge with `rst_n`=0, including mid-frame.
  - State goes to IDLE, all counters and pointers to 0, all flags to 0.
  - A frame interrupted by reset is lost.
  - After reset is released while `rx` is low, no start bit is detected until a 1→0 transition of `rxs` is seen.

## Timing
- **Reset values.** `rx_rdata`=8'h00 (storage is also cleared), `rx_fifo_dvalid`=0, `rx_fifo_full`=0, `rx_fifo_rcntr`=0, `rx_fifo_overrun`=0, `rx_fifo_underrun`=0, `rx_frame_err`=0.
- **Pin to detection.** A pin edge appears on `rxs` 2 or 3 clks later, depending on phase. E is the first cycle with `rxs`=0.
- **Tick schedule.** Tick `tk`=k of bit b (start bit is b=0, data bits are b=1..8, stop bit is b=9) occurs at cycle E + (16·b + k + 1)·CLK_DIV.
- **Push and flags.**
  - `push` is asserted one cycle after the stop-bit `tk`=9 tick.
  - `rx_fifo_dvalid` and `rx_fifo_rcntr` update on the edge after `push`, at cycle E + 154·CLK_DIV + 2.
  - `rx_frame_err` rises on the same edge.
- **Read side.**
  - A pop is visible on the next edge: `rx_rdata` shows the next entry and `rx_fifo_rcntr` decrements.
  - `rx_fifo_full` and `rx_fifo_dvalid` are registered and change on the same edge as `rx_fifo_rcntr`.
- **Back-to-back frames.** A new start bit is accepted from the cycle after the return to IDLE. The stop bit needs to be only about 10/16 of a bit long.
- **Throughput.** One byte per 160·CLK_DIV clks is sustained indefinitely with no drops while the consumer pops at least that fast.

## Test plan
- **Reset.** CLK_DIV=4. Drive `rx`=1 and assert `rst_n`=0 for 3 clks. Then expect all outputs at their reset values and, for 2000 clks, count 0 and no flags set.
- **Single byte.** Send 8'hA5 at 64 clks per bit. Expect `rx_fifo_dvalid` rising at E+618 (±0), `rx_rdata`=8'hA5 and count=1. One `rx_rden` pulse then gives count=0 and dvalid=0.
- **Glitch and framing error.**
  - Hold `rx` low for 20 clks, then return it high. Expect no byte and no flag.
  - Send 8'h3C with the stop bit forced low and `rx` held low for 200 clks. Expect `rx_frame_err`=1 and count=0.
  - Release `rx` high, then send 8'h11. Expect 8'h11 to be received.
- **Full and overrun.**
  - With no pops, send 9 bytes 8'h01..8'h09. Expect `rx_fifo_full`=1 after byte 8 and `rx_fifo_overrun`=1 after byte 9.
  - Eight pops then return 8'h01..8'h08 in order.
  - Pulse `err_clr` and expect `rx_fifo_overrun`=0.
- **Underrun and simultaneous events.**
  - Pulse `rx_rden` while empty. Expect `rx_fifo_underrun`=1 and count=0.
  - With the FIFO full, hold `rx_rden` in the push cycle. Expect count=8, no overrun, and correct order.
  - Assert `err_clr` in the same cycle as a new frame error. Expect `rx_frame_err`=1.
- **Reset mid-frame.** Assert `rst_n`=0 during data bit 4 of a frame. Expect no byte and count=0. The next full frame, 8'h5A, must be received correctly.
